pixel_row_sched: RTL and testbench

Frame-level scheduler for the pixel ingest path: sequences one DMA row transfer per image row and gates the AXI-Stream pixel receiver so it accepts exactly one row per command. It sits between the software-facing control registers and the DMA command port / stream receiver. It checks every row's beat count against the configured width and reports frame completion or error.

---
 rtl/pixel_row_sched.sv | 167 ++++++++++++++++
 tb/tb_pixel_row_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_row_sched.sv
// pixel_row_sched: frame-level scheduler for the pixel ingest path.
// Issues one DMA row command per image row, enables the stream receiver
// for exactly one row per command, and checks each row's beat count
// against the configured width.
module pixel_row_sched #(
    parameter int ADDR_W = 32,
    parameter int COL_W  = 10,
    parameter int ROW_W  = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [15:0]       cfg_stride,
    input  logic [COL_W-1:0]  cfg_cols,
    input  logic [ROW_W-1:0]  cfg_rows,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [15:0]       cmd_len,
    output logic              rx_en,
    input  logic              rx_beat,
    input  logic              rx_last,
    output logic [ROW_W-1:0]  row_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RECV
    } state_t;

    state_t            r_state;
    logic              r_cmd_valid;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [15:0]       r_cmd_len;
    logic              r_rx_en;
    logic [ROW_W-1:0]  r_row_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_abort_pend;
    logic [15:0]       r_stride;
    logic [COL_W-1:0]  r_cols;
    logic [ROW_W-1:0]  r_rows;
    logic [COL_W-1:0]  r_beat_cnt;

    logic w_cfg_bad;
    logic w_cnt_at_end;
    logic w_last_row;

    assign w_cfg_bad    = (cfg_cols < COL_W'(3)) || (cfg_rows == '0);
    assign w_cnt_at_end = (r_beat_cnt == (r_cols - COL_W'(1)));
    assign w_last_row   = (r_row_idx == (r_rows - ROW_W'(1)));

    assign cmd_valid = r_cmd_valid;
    assign cmd_addr  = r_cmd_addr;
    assign cmd_len   = r_cmd_len;
    assign rx_en     = r_rx_en;
    assign row_idx   = r_row_idx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

    // Frame sequencing FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_cmd_valid  <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_len    <= '0;
            r_rx_en      <= 1'b0;
            r_row_idx    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_abort_pend <= 1'b0;
            r_stride     <= '0;
            r_cols       <= '0;
            r_rows       <= '0;
            r_beat_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // abort is ignored here, so start+abort simply starts
                    if (start) begin
                        r_stride  <= cfg_stride;
                        r_cols    <= cfg_cols;
                        r_rows    <= cfg_rows;
                        r_cmd_len <= 16'({cfg_cols, 2'b00});
                        if (w_cfg_bad) begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_err        <= 1'b0;
                            r_row_idx    <= '0;
                            r_cmd_addr   <= cfg_base_addr;
                            r_cmd_valid  <= 1'b1;
                            r_busy       <= 1'b1;
                            r_abort_pend <= 1'b0;
                            r_state      <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    // An abort seen while the command is outstanding is held
                    // until the handshake so cmd_valid never drops early.
                    if (r_cmd_valid && cmd_ready) begin
                        r_cmd_valid  <= 1'b0;
                        r_beat_cnt   <= '0;
                        r_abort_pend <= 1'b0;
                        if (r_abort_pend || abort) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_rx_en <= 1'b1;
                            r_state <= RECV;
                        end
                    end
                end

                RECV: begin
                    if (abort) begin
                        r_rx_en <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (rx_beat) begin
                        if (rx_last || w_cnt_at_end) begin
                            // Row ends on tlast or on the expected final beat,
                            // whichever comes first; a mismatch flags err.
                            if (rx_last != w_cnt_at_end) begin
                                r_err <= 1'b1;
                            end
                            r_rx_en <= 1'b0;
                            if (w_last_row) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end else begin
                                r_row_idx   <= r_row_idx + ROW_W'(1);
                                r_cmd_addr  <= r_cmd_addr + ADDR_W'(r_stride);
                                r_cmd_valid <= 1'b1;
                                r_state     <= ISSUE;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + COL_W'(1);
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_row_sched.sv
// tb_pixel_row_sched: directed self-checking bench for pixel_row_sched.
module tb_pixel_row_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        abort;
    logic [31:0] cfg_base_addr;
    logic [15:0] cfg_stride;
    logic [9:0]  cfg_cols;
    logic [9:0]  cfg_rows;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        rx_en;
    logic        rx_beat;
    logic        rx_last;
    logic [9:0]  row_idx;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    pixel_row_sched #(
        .ADDR_W(32),
        .COL_W (10),
        .ROW_W (10)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .abort        (abort),
        .cfg_base_addr(cfg_base_addr),
        .cfg_stride   (cfg_stride),
        .cfg_cols     (cfg_cols),
        .cfg_rows     (cfg_rows),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .rx_en        (rx_en),
        .rx_beat      (rx_beat),
        .rx_last      (rx_last),
        .row_idx      (row_idx),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] stride,
                            input logic [9:0] cols, input logic [9:0] rows);
        cfg_base_addr = base;
        cfg_stride    = stride;
        cfg_cols      = cols;
        cfg_rows      = rows;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    // Expect an outstanding command, hold cmd_ready low for 'wait_cyc' cycles,
    // then complete the handshake.
    task automatic issue_row(input string tag, input logic [31:0] exp_addr,
                             input logic [15:0] exp_len, input logic [9:0] exp_row,
                             input int wait_cyc);
        chk({tag, " cmd_valid"}, cmd_valid, 1);
        chk({tag, " cmd_addr"},  cmd_addr,  exp_addr);
        chk({tag, " cmd_len"},   cmd_len,   exp_len);
        chk({tag, " row_idx"},   row_idx,   exp_row);
        chk({tag, " rx_en pre"}, rx_en,     0);
        cmd_ready = 1'b0;
        for (int i = 0; i < wait_cyc; i++) begin
            tick();
            chk({tag, " hold valid"}, cmd_valid, 1);
            chk({tag, " hold addr"},  cmd_addr,  exp_addr);
            chk({tag, " hold rx_en"}, rx_en,     0);
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk({tag, " hs valid"}, cmd_valid, 0);
        chk({tag, " hs rx_en"}, rx_en,     1);
    endtask

    // Present n beats back to back; rx_last is set on beat 'last_at' (0 = never).
    task automatic send_beats(input int n, input int last_at);
        for (int i = 1; i <= n; i++) begin
            rx_beat = 1'b1;
            rx_last = (i == last_at);
            tick();
        end
        rx_beat = 1'b0;
        rx_last = 1'b0;
    endtask

    initial begin
        rstn          = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        cfg_base_addr = '0;
        cfg_stride    = '0;
        cfg_cols      = '0;
        cfg_rows      = '0;
        cmd_ready     = 1'b0;
        rx_beat       = 1'b0;
        rx_last       = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst cmd_valid", cmd_valid, 0);
        chk("rst rx_en",     rx_en,     0);
        chk("rst busy",      busy,      0);
        chk("rst done",      done,      0);
        chk("rst err",       err,       0);
        chk("rst row_idx",   row_idx,   0);
        chk("rst cmd_addr",  cmd_addr,  0);
        chk("rst cmd_len",   cmd_len,   0);
        rstn = 1'b1;
        tick();

        // Nominal 3-row frame, start together with abort (start wins)
        abort = 1'b1;
        do_start(32'h1000, 16'h0400, 10'd4, 10'd3);
        abort = 1'b0;
        chk("f1 busy", busy, 1);
        chk("f1 err",  err,  0);
        issue_row("f1r0", 32'h1000, 16'd16, 10'd0, 0);
        send_beats(4, 4);
        chk("f1r0 end rx_en", rx_en, 0);
        issue_row("f1r1", 32'h1400, 16'd16, 10'd1, 0);
        send_beats(3, 0);
        chk("f1r1 mid rx_en", rx_en, 1);
        send_beats(1, 1);
        issue_row("f1r2", 32'h1800, 16'd16, 10'd2, 0);
        send_beats(4, 4);
        chk("f1 done",     done,      1);
        chk("f1 busy end", busy,      0);
        chk("f1 rx_en end", rx_en,    0);
        chk("f1 valid end", cmd_valid, 0);
        chk("f1 err end",  err,       0);
        tick();
        chk("f1 done pulse", done, 0);

        // Back-pressured command: cmd_ready low for 5 cycles per command
        do_start(32'h2000, 16'h0100, 10'd5, 10'd2);
        issue_row("f2r0", 32'h2000, 16'd20, 10'd0, 5);
        send_beats(5, 5);
        issue_row("f2r1", 32'h2100, 16'd20, 10'd1, 5);
        send_beats(5, 5);
        chk("f2 done", done, 1);
        chk("f2 err",  err,  0);
        tick();

        // Early tlast on beat 2 of row 0
        do_start(32'h3000, 16'h0040, 10'd4, 10'd2);
        issue_row("f3r0", 32'h3000, 16'd16, 10'd0, 0);
        send_beats(2, 2);
        chk("f3 early err", err,   1);
        chk("f3 early rx",  rx_en, 0);
        issue_row("f3r1", 32'h3040, 16'd16, 10'd1, 0);
        send_beats(4, 4);
        chk("f3 done",       done, 1);
        chk("f3 err sticky", err,  1);
        tick();

        // Missing tlast on row 0; start must clear err
        do_start(32'h3000, 16'h0040, 10'd4, 10'd2);
        chk("f4 err clr", err, 0);
        issue_row("f4r0", 32'h3000, 16'd16, 10'd0, 0);
        send_beats(4, 0);
        chk("f4 miss err", err, 1);
        issue_row("f4r1", 32'h3040, 16'd16, 10'd1, 0);
        send_beats(4, 4);
        chk("f4 done", done, 1);
        tick();

        // Bad configurations
        do_start(32'h4000, 16'h0010, 10'd2, 10'd3);
        chk("bad cols err",   err,       1);
        chk("bad cols done",  done,      1);
        chk("bad cols busy",  busy,      0);
        chk("bad cols valid", cmd_valid, 0);
        tick();
        chk("bad cols pulse", done, 0);
        do_start(32'h4000, 16'h0010, 10'd4, 10'd0);
        chk("bad rows err",   err,       1);
        chk("bad rows done",  done,      1);
        chk("bad rows busy",  busy,      0);
        chk("bad rows valid", cmd_valid, 0);
        tick();

        // Abort during RECV of row 1
        do_start(32'h5000, 16'h0200, 10'd4, 10'd3);
        issue_row("f5r0", 32'h5000, 16'd16, 10'd0, 0);
        send_beats(4, 4);
        issue_row("f5r1", 32'h5200, 16'd16, 10'd1, 0);
        send_beats(2, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("f5 abort busy",  busy,      0);
        chk("f5 abort rx_en", rx_en,     0);
        chk("f5 abort done",  done,      0);
        chk("f5 abort valid", cmd_valid, 0);
        tick();
        chk("f5 no late done", done, 0);

        // Abort coinciding with the final beat of the frame: abort wins
        do_start(32'h6000, 16'h0100, 10'd4, 10'd1);
        issue_row("f6r0", 32'h6000, 16'd16, 10'd0, 0);
        send_beats(3, 0);
        abort   = 1'b1;
        rx_beat = 1'b1;
        rx_last = 1'b1;
        tick();
        abort   = 1'b0;
        rx_beat = 1'b0;
        rx_last = 1'b0;
        chk("f6 abort done", done, 0);
        chk("f6 abort busy", busy, 0);
        chk("f6 abort err",  err,  0);

        // Abort during ISSUE with cmd_ready low for 3 cycles
        do_start(32'h7000, 16'h0100, 10'd4, 10'd2);
        cmd_ready = 1'b0;
        abort     = 1'b1;
        tick();
        abort     = 1'b0;
        chk("f7 hold1", cmd_valid, 1);
        tick();
        chk("f7 hold2", cmd_valid, 1);
        tick();
        chk("f7 hold3", cmd_valid, 1);
        chk("f7 addr",  cmd_addr,  32'h7000);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("f7 idle busy",  busy,      0);
        chk("f7 idle valid", cmd_valid, 0);
        chk("f7 idle rx_en", rx_en,     0);
        chk("f7 idle done",  done,      0);

        // start pulsed mid-frame is ignored
        do_start(32'h1000, 16'h0400, 10'd4, 10'd2);
        issue_row("f8r0", 32'h1000, 16'd16, 10'd0, 0);
        do_start(32'h8000, 16'h0010, 10'd8, 10'd5);
        chk("f8 ign row",  row_idx, 0);
        chk("f8 ign busy", busy,    1);
        chk("f8 ign rx",   rx_en,   1);
        send_beats(4, 4);
        chk("f8 ign err", err, 0);
        issue_row("f8r1", 32'h1400, 16'd16, 10'd1, 0);
        send_beats(4, 4);
        chk("f8 done", done, 1);
        tick();

        // Reset mid-RECV of row 1
        do_start(32'h9000, 16'h0100, 10'd4, 10'd2);
        issue_row("f9r0", 32'h9000, 16'd16, 10'd0, 0);
        send_beats(4, 4);
        issue_row("f9r1", 32'h9100, 16'd16, 10'd1, 0);
        send_beats(1, 0);
        rstn = 1'b0;
        tick();
        chk("mrst cmd_valid", cmd_valid, 0);
        chk("mrst rx_en",     rx_en,     0);
        chk("mrst busy",      busy,      0);
        chk("mrst done",      done,      0);
        chk("mrst err",       err,       0);
        chk("mrst row_idx",   row_idx,   0);
        chk("mrst cmd_addr",  cmd_addr,  0);
        chk("mrst cmd_len",   cmd_len,   0);
        rstn = 1'b1;
        tick();
        chk("mrst no done", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
